// File: rtl/pulse_synch_pkg.sv
// pulse_synch_pkg: shared state encoding and default parameters for the pulse synchronizer.
package pulse_synch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, GAP = 2'd2} state_t;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_MIN_GAP = 2;
  function automatic int gap_w(input int g);
    return ($clog2(g) > 1) ? $clog2(g) : 1;
  endfunction
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-stage flop synchronizer for a single-bit level crossing clock domains.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= {STAGES{RST_VAL}};
    else     sr <= {sr[STAGES-2:0], d};
  assign q = sr[STAGES-1];
endmodule

// File: rtl/pulse_synch_rx.sv
// pulse_synch_rx: clkB-side four-phase receiver; acks each request, emits one pulse and counts events.
module pulse_synch_rx
  import pulse_synch_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int MIN_GAP     = DEF_MIN_GAP,
  parameter int CNT_W       = 8
) (
  input  logic             clkB,
  input  logic             rst,
  input  logic             req_in,
  input  logic             cnt_clr,
  output logic             ack_out,
  output logic             pulse_out,
  output logic             busy,
  output logic [CNT_W-1:0] evt_cnt
);
  localparam int GW = gap_w(MIN_GAP);
  localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP > 0 ? MIN_GAP - 1 : 0);
  state_t state, state_n;
  logic [GW-1:0] gap, gap_n;
  logic [CNT_W-1:0] cnt_n;
  logic req_s, acc, ack_n;
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync (
    .clk(clkB),
    .rst(rst),
    .d  (req_in),
    .q  (req_s)
  );
  always_ff @(posedge clkB or posedge rst)
    if (rst) begin
      state     <= IDLE;
      gap       <= '0;
      ack_out   <= 1'b0;
      pulse_out <= 1'b0;
      evt_cnt   <= '0;
    end else begin
      state     <= state_n;
      gap       <= gap_n;
      ack_out   <= ack_n;
      pulse_out <= acc;
      evt_cnt   <= cnt_n;
    end
  // requests seen during GAP stay pending on req_s and are taken once back in IDLE
  always_comb begin
    state_n = state;
    gap_n   = gap;
    ack_n   = ack_out;
    acc     = (state == IDLE) && req_s;
    case (state)
      IDLE: if (req_s) begin
        state_n = ACK;
        ack_n   = 1'b1;
      end
      ACK: if (!req_s) begin
        state_n = (MIN_GAP == 0) ? IDLE : GAP;
        gap_n   = GAP_LOAD;
        ack_n   = 1'b0;
      end
      GAP: begin
        state_n = (gap == '0) ? IDLE : GAP;
        gap_n   = (gap == '0) ? gap : gap - GW'(1);
      end
      default: begin
        state_n = IDLE;
        ack_n   = 1'b0;
      end
    endcase
    cnt_n = cnt_clr ? CNT_W'(acc) : evt_cnt + CNT_W'(acc);
  end
  assign busy = (state != IDLE);
endmodule

// File: doc/pulse_synch_rx.md
PULSE_SYNCH_RX -- requirements
Module: pulse_synch_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on req_in; legal values are 2 or more.
REQ-002 Parameter MIN_GAP, default 2, number of idle clkB cycles enforced after ack_out deasserts; 0 means no gap.
REQ-003 Parameter CNT_W, default 8, width of the event counter.
REQ-004 Port clkB, input, 1, the single clock for this block; all flops are clocked on the rising edge of clkB.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port req_in, input, 1, four-phase request level driven from the clkA domain; it is asynchronous to clkB.
REQ-007 Port cnt_clr, input, 1, synchronous clear of evt_cnt.
REQ-008 Port ack_out, output, 1, four-phase acknowledge level returned to the clkA domain; it is driven directly from a flop.
REQ-009 Port pulse_out, output, 1, single-cycle clkB pulse, one per accepted request; it is driven directly from a flop.
REQ-010 Port busy, output, 1, high while the state is not IDLE.
REQ-011 Port evt_cnt, output, CNT_W, count of accepted requests; it wraps modulo 2^CNT_W.

Function
REQ-012 req_in SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is req_s, and only req_s is used by the logic.
REQ-013 The FSM SHALL have three states: IDLE, ACK and GAP.
REQ-014 In IDLE with req_s=1, the next edge SHALL move to ACK and set pulse_out=1 and ack_out=1.
REQ-015 pulse_out SHALL be high for exactly one cycle per IDLE->ACK transition.
REQ-016 Latency SHALL be SYNC_STAGES+1 clkB edges from the first edge that samples req_in=1 to pulse_out=1 (3 edges with default parameters).
REQ-017 In ACK, ack_out SHALL stay 1 while req_s=1.
REQ-018 In ACK with req_s=0, the next edge SHALL set ack_out=0 and move to GAP with the gap counter loaded to MIN_GAP-1; when MIN_GAP=0 it SHALL move directly to IDLE.
REQ-019 In GAP, the gap counter SHALL decrement each edge; the edge on which it is 0 SHALL move to IDLE.
REQ-020 In GAP, req_s=1 SHALL be ignored and not lost: it is accepted on the first IDLE cycle afterwards.
REQ-021 The gap counter SHALL be width max(1, clog2(MIN_GAP)) and SHALL never underflow.
REQ-022 evt_cnt SHALL increment on the same edge that sets pulse_out=1.
REQ-023 cnt_clr=1 SHALL zero evt_cnt.
REQ-024 When cnt_clr=1 coincides with an increment, evt_cnt SHALL become 1.
REQ-025 At all-ones, evt_cnt SHALL wrap to 0 on increment, with no flag.
REQ-026 busy SHALL be combinational from the state: 1 in ACK and GAP, 0 in IDLE.
REQ-027 A req_s pulse shorter than one full handshake cannot occur under a legal four-phase source; if req_s falls in the same cycle IDLE->ACK fires, ACK SHALL exit on the following edge per REQ-018.

Reset
REQ-028 rst=1 SHALL asynchronously force: all synchronizer flops to 0, state IDLE, gap counter 0, pulse_out=0, ack_out=0, evt_cnt=0.
REQ-029 Reset release SHALL take effect on the first clkB edge with rst=0; no pulse SHALL be generated from a req_in level that was held high through reset until req_s has propagated anew.
REQ-030 Reset mid-handshake SHALL drop ack_out immediately (asynchronously); the source is responsible for its own recovery.

Structure
REQ-031 State encodings (IDLE=2'd0, ACK=2'd1, GAP=2'd2) and the default SYNC_STAGES/MIN_GAP values SHALL live in the shared package pulse_synch_pkg.
REQ-032 The synchronizer chain SHALL be a separate sub-module, sync_ff (parameters STAGES and reset value 0), reusable by the clkA-side sender for ack_out.
REQ-033 No combinational path SHALL exist from req_in to any output.

Verification (clkB period 10 ns, clkA period 40 ns, default parameters)
REQ-034 rst=1 for 2 cycles with req_in=1 -> all outputs 0 during reset; pulse_out rises exactly 3 edges after release; evt_cnt=1.
REQ-035 Single handshake: req_in rises -> pulse_out is 1 cycle wide at edge 3; ack_out holds until 3 edges after req_in falls, then busy stays 1 for 2 more cycles.
REQ-036 Three back-to-back handshakes driven by a four-phase clkA-side model -> exactly 3 pulses, evt_cnt=3, no pulse while busy=1.
REQ-037 req_in re-asserted during GAP -> the pulse is deferred to the first IDLE cycle and none is dropped; count is correct.
REQ-038 evt_cnt preloaded to 255 via 255 handshakes, then one more -> evt_cnt=0; cnt_clr on the same edge as a pulse -> evt_cnt=1.
REQ-039 rst asserted while in ACK -> ack_out=0 within the same cycle, state IDLE; a subsequent handshake completes normally.
